// File: rtl/i2c_tx_fifo_ctrl.sv
// Transmit-FIFO sequencer for the APB I2C peripheral.
// The block gates host pushes into the TX byte FIFO and tracks its occupancy.
// On a start command it drains xfer_len bytes from the FIFO head to the I2C
// byte engine. It reports busy, done, aborted and underrun status.
// Optional feature: define I2C_FIFO_CTRL_TIMEOUT_EN to enable the
// empty-FIFO stall counter and the underrun abort in FETCH.
//
// Handshake: byte_data is valid whenever byte_req is high. Both hold steady
// until the engine raises byte_ack. The byte is consumed in the cycle where
// byte_req and byte_ack are both high.
module i2c_tx_fifo_ctrl #(
    parameter int DEPTH       = 8,
    parameter int LEN_W       = 8,
    parameter int STALL_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic             abort,
    input  logic             host_push,
    input  logic [7:0]       fifo_rdata,
    output logic             fifo_w_enable,
    output logic             fifo_r_enable,
    output logic             byte_req,
    output logic [7:0]       byte_data,
    input  logic             byte_ack,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             underrun,
    output logic [3:0]       level,
    output logic             push_drop
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OFFER = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    // Elaboration-time guard: the stall counter is 8 bits wide.
    if (STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_stall_limit
        $error("STALL_LIMIT must be in 1..255");
    end

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_req_q, byte_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [3:0]       level_q, level_d;
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
    localparam logic [7:0] STALL_L = 8'(STALL_LIMIT);
    logic [7:0]       stall_q, stall_d;
    logic             underrun_q, underrun_d;
`endif

    // Next-state, datapath and FIFO-strobe decode for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        byte_data_d   = byte_data_q;
        aborted_d     = aborted_q;
        fifo_r_enable = 1'b0;
        fifo_w_enable = host_push && (level_q != DEPTH_L);
        push_drop     = host_push && (level_q == DEPTH_L);
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
        stall_d       = stall_q;
        underrun_d    = underrun_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // A zero length still enters FETCH. FETCH then finishes at
                // once without popping, so done lands two cycles after start
                // just like any other completion.
                if (start) begin
                    remaining_d = xfer_len;
                    aborted_d   = 1'b0;
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
                    underrun_d  = 1'b0;
                    stall_d     = 8'd0;
`endif
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if (level_q != 4'd0) begin
                    byte_data_d   = fifo_rdata;
                    fifo_r_enable = 1'b1;
                    state_d       = S_OFFER;
                end else begin
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
                    stall_d = stall_q + 8'd1;
                    if (stall_d == STALL_L) begin
                        underrun_d = 1'b1;
                        state_d    = S_DONE;
                    end
`endif
                end
            end
            S_OFFER: begin
                // Abort beats a simultaneous ack; the popped byte is dropped.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (byte_ack) begin
                    remaining_d = remaining_q - LEN_W'(1);
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
                    stall_d     = 8'd0;
`endif
                    state_d     = (remaining_q == LEN_W'(1)) ? S_DONE : S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_req_d = (state_d == S_OFFER);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);

        unique case ({fifo_w_enable, fifo_r_enable})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    // State and registered outputs. Reset also restarts occupancy, which
    // matches the FIFO pointers restarting under the same reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            byte_data_q <= 8'h00;
            byte_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            level_q     <= 4'd0;
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
            stall_q     <= 8'd0;
            underrun_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            byte_data_q <= byte_data_d;
            byte_req_q  <= byte_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            level_q     <= level_d;
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
            stall_q     <= stall_d;
            underrun_q  <= underrun_d;
`endif
        end
    end

    assign byte_req  = byte_req_q;
    assign byte_data = byte_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign level     = level_q;
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
    assign underrun  = underrun_q;
`else
    assign underrun  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_tx_fifo_ctrl.sv
// Bench for i2c_tx_fifo_ctrl. A small byte FIFO lives in the bench. The
// reference model tracks the accepted bytes in a queue and keeps an
// occupancy count.
module tb_i2c_tx_fifo_ctrl;
  localparam int DEPTH       = 8;
  localparam int LEN_W       = 8;
  localparam int STALL_LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] xfer_len;
  logic             abort;
  logic             host_push;
  logic [7:0]       host_wdata;
  logic [7:0]       fifo_rdata;
  logic             fifo_w_enable;
  logic             fifo_r_enable;
  logic             byte_req;
  logic [7:0]       byte_data;
  logic             byte_ack;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             underrun;
  logic [3:0]       level;
  logic             push_drop;

  int checks   = 0;
  int failures = 0;

  // reference model: bytes accepted into the FIFO, oldest first
  logic [7:0] exp_q[$];
  int         model_level = 0;

  // bench-side FIFO storage
  logic [7:0] mem [0:7];
  logic [2:0] wp, rp;

  i2c_tx_fifo_ctrl #(
    .DEPTH(DEPTH), .LEN_W(LEN_W), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .xfer_len(xfer_len), .abort(abort),
    .host_push(host_push), .fifo_rdata(fifo_rdata),
    .fifo_w_enable(fifo_w_enable), .fifo_r_enable(fifo_r_enable),
    .byte_req(byte_req), .byte_data(byte_data), .byte_ack(byte_ack),
    .busy(busy), .done(done), .aborted(aborted), .underrun(underrun),
    .level(level), .push_drop(push_drop)
  );

  // clock
  always #5 clk = ~clk;

  // FIFO storage driven by the DUT strobes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= 3'd0;
      rp <= 3'd0;
    end else begin
      if (fifo_w_enable) begin
        mem[wp] <= host_wdata;
        wp <= wp + 3'd1;
      end
      if (fifo_r_enable) rp <= rp + 3'd1;
    end
  end
  assign fifo_rdata = mem[rp];

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic acc;
    acc = (model_level != DEPTH);
    host_push  = 1'b1;
    host_wdata = d;
    #1;
    chk("w_enable", {31'd0, fifo_w_enable}, {31'd0, acc});
    chk("push_drop", {31'd0, push_drop}, {31'd0, !acc});
    step();
    host_push = 1'b0;
    if (acc) begin
      exp_q.push_back(d);
      model_level++;
    end
    chk("level_push", {28'd0, level}, model_level);
  endtask

  task automatic start_xfer(input int len);
    start    = 1'b1;
    xfer_len = len[LEN_W-1:0];
    step();
    start = 1'b0;
    chk("busy_start", {31'd0, busy}, 1);
  endtask

  // wait for one offered byte, check it, hold a random time, then ack it
  task automatic serve_byte(input bit do_abort, input int max_delay, output int waited);
    logic [7:0] e;
    int d;
    waited = 0;
    while (byte_req !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    chk("req_wait", {31'd0, byte_req}, 1);
    e = exp_q.pop_front();
    model_level--;
    chk("byte_data", {24'd0, byte_data}, {24'd0, e});
    chk("level_offer", {28'd0, level}, model_level);
    d = $urandom_range(0, max_delay);
    repeat (d) begin
      step();
      chk("req_hold", {31'd0, byte_req}, 1);
      chk("data_hold", {24'd0, byte_data}, {24'd0, e});
    end
    byte_ack = 1'b1;
    abort    = do_abort;
    step();
    byte_ack = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic done_check();
    chk("done_pulse", {31'd0, done}, 1);
    chk("busy_in_done", {31'd0, busy}, 1);
    step();
    chk("done_clear", {31'd0, done}, 0);
    chk("busy_clear", {31'd0, busy}, 0);
  endtask

  task automatic serve(input int n, input int max_delay);
    int w;
    for (int i = 0; i < n; i++) serve_byte(1'b0, max_delay, w);
    done_check();
  endtask

  initial begin
    int w;
    int n;
    int len;
    rst = 1'b1; start = 1'b0; xfer_len = '0; abort = 1'b0;
    host_push = 1'b0; host_wdata = 8'h00; byte_ack = 1'b0;

    // reset state
    step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_req", {31'd0, byte_req}, 0);
    chk("rst_data", {24'd0, byte_data}, 0);
    chk("rst_level", {28'd0, level}, 0);
    chk("rst_aborted", {31'd0, aborted}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_wen", {31'd0, fifo_w_enable}, 0);
    chk("rst_ren", {31'd0, fifo_r_enable}, 0);
    chk("rst_drop", {31'd0, push_drop}, 0);
    rst = 1'b0;
    step();

    // directed three-byte transfer, ack in first OFFER cycle
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    start_xfer(3);
    chk("req_cycle1", {31'd0, byte_req}, 0);
    #1;
    chk("pop_cycle1", {31'd0, fifo_r_enable}, 1);
    step();
    chk("req_cycle2", {31'd0, byte_req}, 1);
    serve_byte(1'b0, 0, w);
    chk("wait_b1", w, 0);
    serve_byte(1'b0, 0, w);
    chk("wait_b2", w, 1);
    serve_byte(1'b0, 0, w);
    chk("wait_b3", w, 1);
    done_check();
    chk("level_after3", {28'd0, level}, 0);

    // overflow: nine pushes into an empty FIFO
    for (int i = 0; i < 9; i++) push_byte(8'($urandom));
    chk("level_full", {28'd0, level}, DEPTH);
    start_xfer(1);
    host_push  = 1'b1;
    host_wdata = 8'h5A;
    #1;
    chk("full_pop", {31'd0, fifo_r_enable}, 1);
    chk("full_wen", {31'd0, fifo_w_enable}, 0);
    chk("full_drop", {31'd0, push_drop}, 1);
    step();
    host_push = 1'b0;
    serve(1, 1);
    chk("level_after_pop", {28'd0, level}, DEPTH - 1);
    start_xfer(DEPTH - 1);
    serve(DEPTH - 1, 2);

    // empty-FIFO stall
    start_xfer(2);
`ifdef I2C_FIFO_CTRL_TIMEOUT_EN
    repeat (3) step();
    chk("stall_underrun0", {31'd0, underrun}, 0);
    chk("stall_done0", {31'd0, done}, 0);
    chk("stall_busy", {31'd0, busy}, 1);
    step();
    chk("underrun_set", {31'd0, underrun}, 1);
    done_check();
    chk("underrun_sticky", {31'd0, underrun}, 1);
`else
    repeat (10) step();
    chk("stall_busy", {31'd0, busy}, 1);
    chk("stall_req", {31'd0, byte_req}, 0);
    chk("stall_done", {31'd0, done}, 0);
    chk("stall_underrun", {31'd0, underrun}, 0);
    push_byte(8'h11);
    serve_byte(1'b0, 1, w);
    push_byte(8'h22);
    serve_byte(1'b0, 1, w);
    done_check();
`endif

    // abort together with ack on the second of five bytes
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    start_xfer(5);
    chk("abort_cleared_start", {31'd0, aborted}, 0);
    serve_byte(1'b0, 1, w);
    serve_byte(1'b1, 1, w);
    chk("aborted_set", {31'd0, aborted}, 1);
    chk("abort_done", {31'd0, done}, 1);
    chk("abort_level", {28'd0, level}, model_level);
    chk("abort_level3", {28'd0, level}, 3);
    step();
    chk("abort_busy_off", {31'd0, busy}, 0);
    chk("aborted_sticky", {31'd0, aborted}, 1);

    // zero-length transfer with data still queued
    start_xfer(0);
    #1;
    chk("zero_no_pop", {31'd0, fifo_r_enable}, 0);
    chk("zero_aborted_clr", {31'd0, aborted}, 0);
    chk("zero_underrun_clr", {31'd0, underrun}, 0);
    chk("zero_done_c1", {31'd0, done}, 0);
    step();
    chk("zero_level", {28'd0, level}, 3);
    done_check();

    // drain the leftover bytes
    start_xfer(model_level);
    serve(model_level, 2);

    // randomized rounds
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, DEPTH - model_level);
      for (int i = 0; i < n; i++) push_byte(8'($urandom));
      if (model_level > 0) begin
        len = $urandom_range(1, model_level);
        start_xfer(len);
        serve(len, 3);
        chk("rand_level", {28'd0, level}, model_level);
      end
    end

    // reset while a byte is offered
    if (model_level > 0) begin
      start_xfer(model_level);
      serve(model_level, 0);
    end
    push_byte(8'h3C);
    push_byte(8'h4D);
    start_xfer(2);
    step();
    chk("pre_rst_req", {31'd0, byte_req}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, byte_req}, 0);
    chk("mid_rst_data", {24'd0, byte_data}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_level", {28'd0, level}, 0);
    chk("mid_rst_ren", {31'd0, fifo_r_enable}, 0);
    step();
    rst = 1'b0;
    exp_q.delete();
    model_level = 0;
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_level", {28'd0, level}, 0);
    push_byte(8'h77);
    start_xfer(1);
    serve(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
